// File: rtl/jtkicker_romslot.sv
// ROM responder for the Konami tile/sprite fetchers: a two-entry word cache
// that fills misses with a two-beat 16-bit SDRAM burst.
module jtkicker_romslot #(
  parameter int unsigned       AW     = 13,
  parameter int unsigned       SDW    = 22,
  parameter logic [SDW-1:0]    OFFSET = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cs,
  input  logic [AW-1:0]  rom_addr,
  output logic [31:0]    rom_data,
  output logic           rom_ok,
  output logic [SDW-1:0] sdram_addr,
  output logic           sdram_req,
  input  logic           sdram_ack,
  input  logic           sdram_dst,
  input  logic [15:0]    sdram_data
);

  typedef enum logic [1:0] {IDLE, REQ, LO, HI} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   tag        [2];
  logic [31:0]     cache_data [2];
  logic [1:0]      valid;
  logic            ptr;
  logic [AW-1:0]   fetch_addr;
  logic [AW-1:0]   addr_q;
  logic [15:0]     lo;
  logic            hit_q;
  logic [1:0]      match;
  logic            hit;
  logic [31:0]     hit_data;
  logic            start;
  logic            fill;
  logic [SDW-1:0]  word_addr;

  assign word_addr = OFFSET + SDW'({rom_addr, 1'b0});

  // Lookup sees the contents before any fill on this edge, so a fill of the
  // current address still reads as a miss for one cycle.
  always_comb begin
    match[0] = valid[0] && (tag[0] == rom_addr);
    match[1] = valid[1] && (tag[1] == rom_addr);
    hit      = |match;
    hit_data = '0;
    if (match[0])      hit_data = cache_data[0];
    else if (match[1]) hit_data = cache_data[1];
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    fill     = 1'b0;
    case (state)
      IDLE: if (cs && !hit) begin
        start    = 1'b1;
        state_nx = REQ;
      end
      REQ:  if (sdram_ack) state_nx = LO;
      LO:   if (sdram_dst) state_nx = HI;
      HI:   if (sdram_dst) begin
        fill     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sdram_req = (state == REQ);
  assign rom_ok    = hit_q && (rom_addr == addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      ptr        <= 1'b0;
      hit_q      <= 1'b0;
      rom_data   <= '0;
      addr_q     <= '0;
      sdram_addr <= '0;
    end else begin
      state    <= state_nx;
      hit_q    <= hit;
      rom_data <= hit_data;
      addr_q   <= rom_addr;
      if (start) begin
        fetch_addr <= rom_addr;
        sdram_addr <= word_addr;
      end
      if (state == LO && sdram_dst) lo <= sdram_data;
      if (fill) begin
        tag[ptr]        <= fetch_addr;
        cache_data[ptr] <= {sdram_data, lo};
        valid[ptr]      <= 1'b1;
        ptr             <= ~ptr;
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_romslot.sv
// Directed cycle-table bench for jtkicker_romslot, plus a second instance
// exercising the region offset wrap and the cs gate.
module tb_jtkicker_romslot;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic [12:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_dst;
  logic [15:0] sdram_data;

  logic        cs2;
  logic [12:0] rom_addr2;
  logic [31:0] rom_data2;
  logic        rom_ok2;
  logic [21:0] sdram_addr2;
  logic        sdram_req2;
  logic        sdram_ack2;
  logic        sdram_dst2;
  logic [15:0] sdram_data2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  jtkicker_romslot #(.AW(13), .SDW(22), .OFFSET(22'h0)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_data(sdram_data)
  );

  jtkicker_romslot #(.AW(13), .SDW(22), .OFFSET(22'h3FFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .cs(cs2), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .rom_ok(rom_ok2),
    .sdram_addr(sdram_addr2), .sdram_req(sdram_req2), .sdram_ack(sdram_ack2),
    .sdram_dst(sdram_dst2), .sdram_data(sdram_data2)
  );

  typedef struct {
    logic        rst;
    logic        cs;
    logic [12:0] addr;
    logic        ack;
    logic        dst;
    logic [15:0] sd;
    logic        e_ok;
    logic        e_req;
    logic        c_data;
    logic [31:0] e_data;
    logic        c_addr;
    logic [21:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c, input logic [12:0] a,
                     input logic k, input logic d, input logic [15:0] s,
                     input logic ok, input logic rq,
                     input logic cd, input logic [31:0] ed,
                     input logic ca, input logic [21:0] ea);
    vec_t v;
    v.rst = r; v.cs = c; v.addr = a; v.ack = k; v.dst = d; v.sd = s;
    v.e_ok = ok; v.e_req = rq; v.c_data = cd; v.e_data = ed;
    v.c_addr = ca; v.e_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int unsigned idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step2(input logic c, input logic k, input logic d,
                       input logic [15:0] s);
    @(posedge clk);
    #1;
    cs2 = c; sdram_ack2 = k; sdram_dst2 = d; sdram_data2 = s;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; rom_addr = '0;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = '0;
    cs2 = 1'b0; rom_addr2 = 13'd1;
    sdram_ack2 = 1'b0; sdram_dst2 = 1'b0; sdram_data2 = '0;

    //  rst cs addr      ack dst data      ok req cd data          ca addr
    add(1, 1, 13'h000, 0, 0, 16'h0000, 0, 0, 1, 32'h0,          1, 22'h0);
    add(1, 1, 13'h000, 0, 0, 16'h0000, 0, 0, 1, 32'h0,          1, 22'h0);
    add(0, 1, 13'h000, 0, 0, 16'h0000, 0, 0, 1, 32'h0,          1, 22'h0);
    add(0, 1, 13'h000, 0, 0, 16'h0000, 0, 1, 0, 32'h0,          1, 22'h0);
    add(1, 1, 13'h012, 0, 0, 16'h0000, 0, 1, 0, 32'h0,          0, 22'h0);
    add(1, 1, 13'h012, 0, 0, 16'h0000, 0, 0, 1, 32'h0,          1, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 0, 1, 0, 32'h0,          1, 22'h24);
    add(0, 1, 13'h012, 0, 1, 16'hDEAD, 0, 1, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 1, 0, 16'h0000, 0, 1, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 0, 1, 16'h1234, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 0, 1, 16'hABCD, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 1, 0, 1, 32'hABCD1234,   0, 22'h0);
    add(0, 1, 13'h034, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h034, 1, 0, 16'h0000, 0, 1, 0, 32'h0,          1, 22'h68);
    add(0, 1, 13'h034, 0, 1, 16'h5555, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h034, 0, 1, 16'h6666, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h034, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h034, 0, 0, 16'h0000, 1, 0, 1, 32'h66665555,   0, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 1, 0, 1, 32'hABCD1234,   0, 22'h0);
    add(0, 1, 13'h056, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h056, 1, 0, 16'h0000, 0, 1, 0, 32'h0,          1, 22'hAC);
    add(0, 1, 13'h056, 0, 1, 16'h0001, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h056, 0, 1, 16'h0002, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h056, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h056, 0, 0, 16'h0000, 1, 0, 1, 32'h00020001,   0, 22'h0);
    add(0, 1, 13'h034, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h034, 0, 0, 16'h0000, 1, 0, 1, 32'h66665555,   0, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 1, 0, 16'h0000, 0, 1, 0, 32'h0,          1, 22'h24);
    add(0, 1, 13'h012, 0, 1, 16'hAAAA, 0, 0, 0, 32'h0,          0, 22'h0);
    add(1, 1, 13'h012, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 0, 1, 16'hBBBB, 0, 0, 1, 32'h0,          1, 22'h0);
    add(0, 1, 13'h012, 1, 0, 16'h0000, 0, 1, 0, 32'h0,          1, 22'h24);
    add(0, 1, 13'h040, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h040, 0, 1, 16'h1111, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h040, 0, 1, 16'h2222, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h040, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h040, 1, 0, 16'h0000, 0, 1, 0, 32'h0,          1, 22'h80);
    add(0, 1, 13'h040, 0, 1, 16'h3333, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h040, 0, 1, 16'h4444, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h040, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h040, 0, 0, 16'h0000, 1, 0, 1, 32'h44443333,   0, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 1, 13'h012, 0, 0, 16'h0000, 1, 0, 1, 32'h22221111,   0, 22'h0);
    add(0, 0, 13'h077, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 0, 13'h077, 1, 1, 16'hFFFF, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 0, 13'h077, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 0, 13'h040, 0, 0, 16'h0000, 0, 0, 0, 32'h0,          0, 22'h0);
    add(0, 0, 13'h040, 0, 0, 16'h0000, 1, 0, 1, 32'h44443333,   0, 22'h0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; cs = vecs[i].cs; rom_addr = vecs[i].addr;
      sdram_ack = vecs[i].ack; sdram_dst = vecs[i].dst;
      sdram_data = vecs[i].sd;
      @(negedge clk);
      check("rom_ok", i, 32'(rom_ok), 32'(vecs[i].e_ok));
      check("sdram_req", i, 32'(sdram_req), 32'(vecs[i].e_req));
      if (vecs[i].c_data) check("rom_data", i, rom_data, vecs[i].e_data);
      if (vecs[i].c_addr) check("sdram_addr", i, 32'(sdram_addr), 32'(vecs[i].e_addr));
    end

    // Offset region wrap and cs gate on the second instance.
    check("wrap_idle_req", 100, 32'(sdram_req2), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step2(1'b0, 1'b0, 1'b0, 16'h0);
      check("wrap_cs_low_req", 101 + k, 32'(sdram_req2), 32'd0);
    end
    step2(1'b1, 1'b0, 1'b0, 16'h0);
    check("wrap_req_pre", 110, 32'(sdram_req2), 32'd0);
    step2(1'b1, 1'b1, 1'b0, 16'h0);
    check("wrap_req", 111, 32'(sdram_req2), 32'd1);
    check("wrap_addr", 112, 32'(sdram_addr2), 32'h0);
    step2(1'b1, 1'b0, 1'b1, 16'hCAFE);
    check("wrap_req_drop", 113, 32'(sdram_req2), 32'd0);
    step2(1'b1, 1'b0, 1'b1, 16'hBEEF);
    step2(1'b0, 1'b0, 1'b0, 16'h0);
    check("wrap_ok_early", 114, 32'(rom_ok2), 32'd0);
    step2(1'b0, 1'b0, 1'b0, 16'h0);
    check("wrap_ok", 115, 32'(rom_ok2), 32'd1);
    check("wrap_data", 116, rom_data2, 32'hBEEFCAFE);
    check("wrap_no_refetch", 117, 32'(sdram_req2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtkicker_romslot.md
# jtkicker_romslot

ROM-side responder for the Konami tile and sprite fetchers. It answers a client's `rom_addr` with a 32-bit `rom_data` word and a `rom_ok` flag. Behind a two-entry cache it fetches each missing word as a two-beat 16-bit SDRAM burst. It sits between a layer renderer (scroll, object) and the SDRAM arbiter, one instance per ROM region.

## Interface
Parameters:
- `AW`, 13: client address width; one address selects one 32-bit word.
- `SDW`, 22: SDRAM word-address width (16-bit words).
- `OFFSET`, 22'h0: SDRAM word base of this ROM region.

Ports:
- `clk`  in  1  system clock (48 MHz); single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `cs`  in  1  client request enable; when low, no new fetch starts.
- `rom_addr`  in  AW  client word address.
- `rom_data`  out  32  fetched word; `{high beat, low beat}`.
- `rom_ok`  out  1  `rom_data` is valid for the current `rom_addr`.
- `sdram_addr`  out  SDW  burst start word address.
- `sdram_req`  out  1  burst request; level, held until acknowledged.
- `sdram_ack`  in  1  arbiter accepted the request.
- `sdram_dst`  in  1  data strobe; one per 16-bit beat.
- `sdram_data`  in  16  beat data, valid while `sdram_dst` is high.

## Operation
- **Cache.** Two entries, each holding a tag of AW bits, data of 32 bits and a valid bit. Lookup compares `rom_addr` against both tags every cycle.
- **Word address.** `sdram_addr = OFFSET + {rom_addr, 1'b0}`. The addition wraps modulo 2^SDW, with no carry-out. The low beat is at the even word and the high beat at the odd word.
- **Replacement.** A one-bit round-robin pointer selects the victim entry. It toggles on every fill.
- **FSM states:**
  - IDLE: if `cs` is high and the lookup misses, latch `rom_addr` into `fetch_addr`, drive `sdram_addr`, raise `sdram_req`, and go to REQ.
  - REQ: keep `sdram_req` high until `sdram_ack` is sampled high. On that cycle drop `sdram_req` and go to LO.
  - LO: on `sdram_dst`, store `sdram_data` as bits [15:0] and go to HI.
  - HI: on `sdram_dst`, write `{sdram_data, lo}` into the victim entry with tag `fetch_addr`, set its valid bit, toggle the pointer, and go to IDLE.
- **Address change mid-fetch.** The burst in progress always completes and fills the cache under the latched `fetch_addr`, not the new address. After returning to IDLE, the new address is looked up; if it misses, a new fetch starts.
- **`cs` low.** No fetch starts. A fetch already in progress completes. `rom_ok` is still reported for hits.
- **`sdram_dst` outside LO/HI.** Ignored. `sdram_ack` outside REQ is ignored.

## Timing
- **Reset values:** `rom_ok=0`, `rom_data=0`, `sdram_req=0`, `sdram_addr=0`, both valid bits 0, pointer 0, state IDLE. Reset applied mid-burst abandons the burst; strobes still pending afterwards are ignored.
- **Output registers.** `rom_data` and a registered hit flag update every cycle from the lookup result.
- **`rom_ok` rule.** `rom_ok = hit_q & (rom_addr == addr_q)`, where `addr_q` is `rom_addr` delayed by one cycle. `rom_ok` therefore goes low in the same cycle `rom_addr` changes.
- **Hit latency.** `rom_ok` is high 1 cycle after a stable hit address is presented.
- **Miss latency.** `sdram_req` rises 1 cycle after the miss is detected. The entry is written on the clock edge that samples the second strobe, and `rom_ok` rises 1 cycle after that edge.
- **Back-to-back.** `sdram_req` may rise the cycle after a fill completes. There is no idle gap requirement.
- **Fill/lookup collision.** A fill and a lookup of the same address in the same cycle counts as a miss for that cycle. It must not start a second fetch, because the FSM is not in IDLE during that cycle.

## Test plan
- **Reset:** hold `rst` for 2 cycles → all outputs 0; `rom_addr=0` with `cs=1` then yields `sdram_req` 1 cycle after reset is released.
- **First miss:** `rom_addr=13'h0012` with `OFFSET=0`; ack 3 cycles later; beats 16'h1234 then 16'hABCD → `sdram_addr=22'h24`, `rom_data=32'hABCD1234`, `rom_ok=1` one cycle after the second beat.
- **Hit / replacement:** fetch 0x12, then 0x34, then return to 0x12 → no `sdram_req`, `rom_ok` after 1 cycle. Then fetch 0x56 → replaces the 0x12 entry (pointer back to 0), so revisiting 0x12 issues a new request.
- **Address change mid-burst:** switch from 0x12 to 0x40 during LO → `rom_ok` stays 0; entry 0x12 is filled; a second request at word 22'h80 follows; `rom_ok=1` only after that burst completes.
- **Reset mid-burst:** assert `rst` in HI → no fill; a stray strobe after reset is ignored; the old address then misses again.
- **Offset and `cs`:** `OFFSET=22'h3FFFFE`, `rom_addr=1` → `sdram_addr=22'h000000` (wrap). With `cs=0` → `sdram_req` never rises.
